// File: rtl/countdown_timer_if.sv
// countdown_timer_if
//   Groups the control/status signals of countdown_timer into one bundle.
//   Handshake: start is accepted on a rising clk edge only while ready=1;
//   load_val and prescale are sampled on that same edge. A start seen while
//   ready=0 is dropped, not queued. done is a one-cycle pulse.
//
//   Signals (master = controller, slave = timer):
//     start     : master->slave  request to load and run
//     load_val  : master->slave  initial count (width bits)
//     prescale  : master->slave  tick divider, one decrement per prescale+1 cycles
//     pause     : master->slave  freeze counting while high
//     abort     : master->slave  cancel the active run without done
//     count     : slave->master  remaining count
//     ready     : slave->master  idle, able to accept start
//     busy      : slave->master  running or paused
//     done      : slave->master  one-cycle completion pulse
//     dbg_state : slave->master  raw FSM state (0 idle, 1 run, 2 paused, 3 done)
interface countdown_timer_if #(
    parameter int width  = 16,
    parameter int pwidth = 8
);
    logic              start;
    logic [width-1:0]  load_val;
    logic [pwidth-1:0] prescale;
    logic              pause;
    logic              abort;
    logic [width-1:0]  count;
    logic              ready;
    logic              busy;
    logic              done;
    logic [1:0]        dbg_state;

    modport master (
        output start, load_val, prescale, pause, abort,
        input  count, ready, busy, done, dbg_state
    );

    modport slave (
        input  start, load_val, prescale, pause, abort,
        output count, ready, busy, done, dbg_state
    );
endinterface

// File: rtl/countdown_timer.sv
// countdown_timer
//   Programmable down-counting timer. A start accepted in IDLE loads the
//   count and prescaler; the count decrements once every prescale+1 cycles
//   and a one-cycle done pulse marks the 1->0 step. Pause freezes progress,
//   abort returns to IDLE without done.
//
//   Ports:
//     clk   : system clock, rising edge
//     reset : asynchronous, active-high
//     bus   : countdown_timer_if slave modport (start/load_val/prescale/
//             pause/abort in; count/ready/busy/done/dbg_state out)
module countdown_timer #(
    parameter int width  = 16,
    parameter int pwidth = 8
) (
    input  logic              clk,
    input  logic              reset,
    countdown_timer_if.slave  bus
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_PAUSED = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    localparam logic [width-1:0]  lp_cnt_one = {{(width-1){1'b0}}, 1'b1};
    localparam logic [pwidth-1:0] lp_psc_one = {{(pwidth-1){1'b0}}, 1'b1};

    state_t            r_state;
    state_t            w_state_nxt;
    logic [width-1:0]  r_count;
    logic [width-1:0]  w_count_nxt;
    logic [pwidth-1:0] r_psc;
    logic [pwidth-1:0] w_psc_nxt;
    logic [pwidth-1:0] r_presc;
    logic [pwidth-1:0] w_presc_nxt;

    // State and datapath registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_count <= '0;
            r_psc   <= '0;
            r_presc <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_count <= w_count_nxt;
            r_psc   <= w_psc_nxt;
            r_presc <= w_presc_nxt;
        end
    end

    // Next-state and datapath update. In RUN, abort beats pause beats tick.
    always_comb begin
        w_state_nxt = r_state;
        w_count_nxt = r_count;
        w_psc_nxt   = r_psc;
        w_presc_nxt = r_presc;
        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    if (bus.load_val != '0) begin
                        w_count_nxt = bus.load_val;
                        w_psc_nxt   = bus.prescale;
                        w_presc_nxt = bus.prescale;
                        w_state_nxt = S_RUN;
                    end else begin
                        w_count_nxt = '0;
                        w_state_nxt = S_DONE;
                    end
                end
            end
            S_RUN: begin
                if (bus.abort) begin
                    w_count_nxt = '0;
                    w_state_nxt = S_IDLE;
                end else if (bus.pause) begin
                    w_state_nxt = S_PAUSED;
                end else if (r_psc == '0) begin
                    // Tick: reload from the latched divider so a changing
                    // prescale port cannot disturb an active run.
                    w_psc_nxt   = r_presc;
                    w_count_nxt = r_count - lp_cnt_one;
                    if (r_count == lp_cnt_one) begin
                        w_state_nxt = S_DONE;
                    end
                end else begin
                    w_psc_nxt = r_psc - lp_psc_one;
                end
            end
            S_PAUSED: begin
                if (bus.abort) begin
                    w_count_nxt = '0;
                    w_state_nxt = S_IDLE;
                end else if (!bus.pause) begin
                    // Resume edge makes no progress.
                    w_state_nxt = S_RUN;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Moore outputs.
    always_comb begin
        bus.count     = r_count;
        bus.ready     = (r_state == S_IDLE);
        bus.busy      = (r_state == S_RUN) || (r_state == S_PAUSED);
        bus.done      = (r_state == S_DONE);
        bus.dbg_state = r_state;
    end

endmodule

// File: tb/tb_countdown_timer.sv
module tb_countdown_timer;

    localparam int W  = 16;
    localparam int PW = 8;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    countdown_timer_if #(.width(W), .pwidth(PW)) bus ();

    countdown_timer #(.width(W), .pwidth(PW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: a run is described by its load value, its tick
    // period and the number of productive edges seen so far.
    bit m_active;
    bit m_frozen;
    bit m_done;
    int m_load;
    int m_period;
    int m_prog;

    function automatic void model_reset();
        m_active = 0;
        m_frozen = 0;
        m_done   = 0;
        m_load   = 0;
        m_period = 1;
        m_prog   = 0;
    endfunction

    function automatic int model_count();
        if (m_active) return m_load - (m_prog / m_period);
        return 0;
    endfunction

    // Applies the inputs present at a rising edge to the model.
    function automatic void model_edge();
        if (m_done) begin
            m_done = 0;
        end else if (!m_active) begin
            if (bus.start === 1'b1) begin
                if (int'(bus.load_val) == 0) begin
                    m_done = 1;
                end else begin
                    m_active = 1;
                    m_frozen = 0;
                    m_load   = int'(bus.load_val);
                    m_period = int'(bus.prescale) + 1;
                    m_prog   = 0;
                end
            end
        end else if (bus.abort === 1'b1) begin
            m_active = 0;
        end else if (m_frozen) begin
            if (bus.pause !== 1'b1) m_frozen = 0;
        end else if (bus.pause === 1'b1) begin
            m_frozen = 1;
        end else begin
            m_prog++;
            if (m_prog == m_load * m_period) begin
                m_active = 0;
                m_done   = 1;
            end
        end
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_outputs(input string ctx);
        check({ctx, "_count"}, 32'(bus.count), 32'(model_count()));
        check({ctx, "_ready"}, 32'(bus.ready), 32'(!m_active && !m_done));
        check({ctx, "_busy"},  32'(bus.busy),  32'(m_active));
        check({ctx, "_done"},  32'(bus.done),  32'(m_done));
    endtask

    // One clock: model follows the edge, outputs checked on the falling edge.
    task automatic cycle(input string ctx);
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_outputs(ctx);
    endtask

    task automatic idle_inputs();
        bus.start    = 1'b0;
        bus.load_val = '0;
        bus.prescale = '0;
        bus.pause    = 1'b0;
        bus.abort    = 1'b0;
    endtask

    task automatic start_run(input int load, input int psc, input string ctx);
        bus.load_val = W'(load);
        bus.prescale = PW'(psc);
        bus.start    = 1'b1;
        cycle(ctx);
        bus.start    = 1'b0;
    endtask

    task automatic wait_done(input int budget, input string ctx, output int edges);
        edges = 0;
        for (int i = 0; i < budget; i++) begin
            cycle(ctx);
            edges++;
            if (bus.done === 1'b1) return;
        end
        n_tests++;
        n_fail++;
        $error("FAIL %s_timeout observed=no_done expected=done_within_%0d", ctx, budget);
    endtask

    int lat;
    int pre;

    initial begin
        idle_inputs();
        model_reset();
        reset = 1'b1;
        #1;
        check_outputs("reset");
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        check_outputs("reset_rel");

        // Basic countdown, no prescale.
        start_run(3, 0, "t1");
        check("t1_first_count", 32'(bus.count), 32'd3);
        wait_done(20, "t1", lat);
        check("t1_latency", 32'(lat), 32'd3);
        cycle("t1_after");
        check("t1_ready_back", 32'(bus.ready), 32'd1);

        // Prescaled countdown.
        start_run(2, 2, "t2");
        check("t2_busy", 32'(bus.busy), 32'd1);
        wait_done(40, "t2", lat);
        check("t2_latency", 32'(lat), 32'd6);
        cycle("t2_after");

        // Zero load goes straight to done.
        start_run(0, 5, "t3");
        check("t3_done", 32'(bus.done), 32'd1);
        check("t3_busy", 32'(bus.busy), 32'd0);
        cycle("t3_after");

        // Pause for 3 cycles after count reaches 3.
        start_run(4, 0, "t4");
        cycle("t4");
        bus.pause = 1'b1;
        for (int i = 0; i < 3; i++) cycle("t4_pause");
        check("t4_frozen", 32'(bus.count), 32'd3);
        check("t4_busy_paused", 32'(bus.busy), 32'd1);
        bus.pause = 1'b0;
        wait_done(40, "t4", lat);
        check("t4_latency", 32'(1 + 3 + lat), 32'd8);
        cycle("t4_after");

        // Start ignored in RUN, then abort at count 2.
        start_run(5, 0, "t5");
        bus.load_val = W'(9);
        bus.start    = 1'b1;
        cycle("t5_ign");
        bus.start    = 1'b0;
        check("t5_start_ignored", 32'(bus.count), 32'd4);
        cycle("t5");
        cycle("t5");
        check("t5_at2", 32'(bus.count), 32'd2);
        bus.abort = 1'b1;
        cycle("t5_abort");
        bus.abort = 1'b0;
        check("t5_abort_count", 32'(bus.count), 32'd0);
        check("t5_abort_ready", 32'(bus.ready), 32'd1);
        cycle("t5_after");

        // Abort together with pause.
        start_run(5, 0, "t5b");
        for (int i = 0; i < 3; i++) cycle("t5b");
        bus.pause = 1'b1;
        bus.abort = 1'b1;
        cycle("t5b_abort");
        bus.pause = 1'b0;
        bus.abort = 1'b0;
        check("t5b_abort_ready", 32'(bus.ready), 32'd1);
        check("t5b_abort_done", 32'(bus.done), 32'd0);
        cycle("t5b_after");

        // Abort from PAUSED.
        start_run(6, 1, "t5c");
        bus.pause = 1'b1;
        cycle("t5c_p");
        cycle("t5c_p");
        bus.abort = 1'b1;
        cycle("t5c_abort");
        bus.abort = 1'b0;
        bus.pause = 1'b0;
        check("t5c_ready", 32'(bus.ready), 32'd1);

        // Start held high across DONE is accepted on the first IDLE cycle.
        bus.load_val = W'(1);
        bus.prescale = '0;
        bus.start    = 1'b1;
        for (int i = 0; i < 5; i++) cycle("t7_held");
        bus.start = 1'b0;
        for (int i = 0; i < 3; i++) cycle("t7_drain");

        // Full-range load starts at all-ones and decrements normally.
        start_run(16'hFFFF, 0, "t8");
        check("t8_full", 32'(bus.count), 32'hFFFF);
        cycle("t8");
        cycle("t8");
        check("t8_dec", 32'(bus.count), 32'hFFFD);
        bus.abort = 1'b1;
        cycle("t8_abort");
        bus.abort = 1'b0;

        // Asynchronous reset mid-run at count 7.
        start_run(10, 0, "t6");
        for (int i = 0; i < 3; i++) cycle("t6");
        check("t6_at7", 32'(bus.count), 32'd7);
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        check_outputs("t6_async");
        check("t6_async_count", 32'(bus.count), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        start_run(2, 1, "t6_new");
        pre = 0;
        wait_done(20, "t6_new", lat);
        check("t6_new_latency", 32'(lat + pre), 32'd4);
        cycle("t6_after");

        // Randomized traffic against the model; prescale also changes mid-run.
        for (int i = 0; i < 600; i++) begin
            bus.start    = ($urandom_range(0, 3) == 0);
            bus.load_val = W'($urandom_range(0, 6));
            bus.prescale = PW'($urandom_range(0, 3));
            bus.pause    = ($urandom_range(0, 4) == 0);
            bus.abort    = ($urandom_range(0, 24) == 0);
            cycle("rnd");
        end
        idle_inputs();
        for (int i = 0; i < 40; i++) cycle("rnd_drain");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
